// File: rtl/blackparrot_fpga_host_pkg.sv
// rtl/blackparrot_fpga_host_pkg.sv - shared types, constants and byte-lane helpers for the host I/O-in initiator
package blackparrot_fpga_host_pkg;

    // Word states consume one command word each; the AXI states run one single-beat transaction.
    typedef enum logic [2:0] {
        e_op,
        e_addr,
        e_data,
        e_aw_w,
        e_b,
        e_ar,
        e_r
    } state_e;

    // Op word layout
    localparam int op_write_bit_lp = 31;
    localparam int op_size_msb_lp  = 1;

    // Size encodings (3 behaves as 4 bytes)
    localparam logic [1:0] size_1b_lp = 2'd0;
    localparam logic [1:0] size_2b_lp = 2'd1;
    localparam logic [1:0] size_4b_lp = 2'd2;

    // AXI constants
    localparam logic [1:0] axi_burst_incr_lp = 2'b01;
    localparam logic [3:0] axi_cache_lp      = 4'b0011;
    localparam logic [1:0] axi_resp_okay_lp  = 2'b00;

    function automatic logic [1:0] eff_size(input logic [1:0] size);
        return (size == 2'd3) ? size_4b_lp : size;
    endfunction

    function automatic logic [7:0] byte_mask(input logic [1:0] size);
        case (eff_size(size))
            size_1b_lp: return 8'h01;
            size_2b_lp: return 8'h03;
            default:    return 8'h0F;
        endcase
    endfunction

    // Lanes past byte 7 fall off the top; misaligned accesses are not rejected.
    function automatic logic [7:0] wstrb_gen(input logic [1:0] size, input logic [2:0] addr_lo);
        return byte_mask(size) << addr_lo;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [63:0] rdata, input logic [1:0] size,
                                                 input logic [2:0] addr_lo);
        logic [63:0] shifted;
        logic [31:0] bit_mask;
        shifted = rdata >> {addr_lo, 3'b000};
        case (eff_size(size))
            size_1b_lp: bit_mask = 32'h0000_00FF;
            size_2b_lp: bit_mask = 32'h0000_FFFF;
            default:    bit_mask = 32'hFFFF_FFFF;
        endcase
        return shifted[31:0] & bit_mask;
    endfunction

endpackage

// File: rtl/blackparrot_fpga_host_areset_fifo.sv
// rtl/blackparrot_fpga_host_areset_fifo.sv - async-reset 1r1w FIFO, valid/ready in, valid/yumi out
//  clk_i, rst_n_i        : clock, async active-low reset
//  v_i, data_i, ready_o  : write side; ready_o is low while in reset or when full
//  v_o, data_o, yumi_i   : read side; yumi_i pops the head and must only be raised with v_o
module blackparrot_fpga_host_areset_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 64
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                push, pop;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Reset gates ready so the host sees backpressure while the block is held in reset.
    assign ready_o = rst_n_i && (count_q != cnt_w_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign push    = v_i && ready_o;
    assign pop     = yumi_i && v_o;

    always_comb begin
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + cnt_w_lp'(1);
        end else if (pop && !push) begin
            count_d = count_q - cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/blackparrot_fpga_host_io_in.sv
// rtl/blackparrot_fpga_host_io_in.sv - host command FIFO to single-beat AXI4 MMIO initiator
//  m_axi_aclk, m_axi_aresetn : clock, async active-low reset
//  m_axi_aw* / m_axi_w* / m_axi_b* : write address, data and response channels (manager side)
//  m_axi_ar* / m_axi_r*      : read address and data channels (manager side)
//  io_cmd_*                  : host command words (op, address, data for writes)
//  io_resp_*                 : read data back to the host, one 32b word per read
//  io_wr_count_o             : completed-write count, wraps
//  io_err_o                  : sticky, set by any non-OKAY bresp/rresp
module blackparrot_fpga_host_io_in
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int M_AXI_ADDR_WIDTH  = 64,
    parameter int M_AXI_DATA_WIDTH  = 64,
    parameter int M_AXI_ID_WIDTH    = 4,
    parameter int fifo_data_width_p = 32,
    parameter int HOST_IO_ELS       = 64
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_aresetn,
    output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [M_AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awlock,
    output logic [3:0]                    m_axi_awcache,
    output logic [2:0]                    m_axi_awprot,
    output logic [3:0]                    m_axi_awqos,
    output logic [3:0]                    m_axi_awregion,
    output logic [M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic                          m_axi_wlast,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [M_AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                    m_axi_bresp,
    output logic [M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [M_AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arlock,
    output logic [3:0]                    m_axi_arcache,
    output logic [2:0]                    m_axi_arprot,
    output logic [3:0]                    m_axi_arqos,
    output logic [3:0]                    m_axi_arregion,
    input  logic [M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [M_AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic                          m_axi_rlast,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          io_cmd_v_i,
    input  logic [fifo_data_width_p-1:0]  io_cmd_data_i,
    output logic                          io_cmd_ready_and_o,
    output logic                          io_resp_v_o,
    output logic [fifo_data_width_p-1:0]  io_resp_data_o,
    input  logic                          io_resp_yumi_i,
    output logic [31:0]                   io_wr_count_o,
    output logic                          io_err_o
);
    state_e        state_q, state_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d, data_q, data_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0]   count_q, count_d;
    logic          err_q, err_d;

    logic                         cmd_v, cmd_yumi, resp_ready, resp_push;
    logic [fifo_data_width_p-1:0] cmd_data;
    logic                         aw_v, w_v, ar_v, b_rdy, r_rdy;

    blackparrot_fpga_host_areset_fifo #(.width_p(fifo_data_width_p), .els_p(HOST_IO_ELS)) cmd_fifo (
        .clk_i(m_axi_aclk), .rst_n_i(m_axi_aresetn),
        .v_i(io_cmd_v_i), .data_i(io_cmd_data_i), .ready_o(io_cmd_ready_and_o),
        .v_o(cmd_v), .data_o(cmd_data), .yumi_i(cmd_yumi)
    );

    blackparrot_fpga_host_areset_fifo #(.width_p(fifo_data_width_p), .els_p(HOST_IO_ELS)) resp_fifo (
        .clk_i(m_axi_aclk), .rst_n_i(m_axi_aresetn),
        .v_i(resp_push), .data_i(lane_extract(m_axi_rdata, size_q, addr_q[2:0])), .ready_o(resp_ready),
        .v_o(io_resp_v_o), .data_o(io_resp_data_o), .yumi_i(io_resp_yumi_i)
    );

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        size_d    = size_q;
        addr_d    = addr_q;
        data_d    = data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        count_d   = count_q;
        err_d     = err_q;
        cmd_yumi  = 1'b0;
        aw_v      = 1'b0;
        w_v       = 1'b0;
        ar_v      = 1'b0;
        b_rdy     = 1'b0;
        r_rdy     = 1'b0;
        resp_push = 1'b0;
        unique case (state_q)
            e_op: if (cmd_v) begin
                cmd_yumi = 1'b1;
                write_d  = cmd_data[op_write_bit_lp];
                size_d   = cmd_data[op_size_msb_lp:0];
                state_d  = e_addr;
            end
            e_addr: if (cmd_v) begin
                cmd_yumi = 1'b1;
                addr_d   = cmd_data;
                state_d  = write_q ? e_data : e_ar;
            end
            e_data: if (cmd_v) begin
                cmd_yumi  = 1'b1;
                data_d    = cmd_data;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = e_aw_w;
            end
            e_aw_w: begin
                // AW and W may complete in either order or together.
                aw_v = !aw_done_q;
                w_v  = !w_done_q;
                if (aw_v && m_axi_awready) aw_done_d = 1'b1;
                if (w_v && m_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d   = e_b;
            end
            e_b: begin
                b_rdy = 1'b1;
                if (m_axi_bvalid) begin
                    count_d = count_q + 32'd1;
                    err_d   = err_q | (m_axi_bresp != axi_resp_okay_lp);
                    state_d = e_op;
                end
            end
            e_ar: begin
                ar_v = 1'b1;
                if (m_axi_arready) state_d = e_r;
            end
            e_r: begin
                // Backpressure from a full response FIFO stalls the R channel rather than dropping data.
                r_rdy = resp_ready;
                if (m_axi_rvalid && resp_ready) begin
                    resp_push = 1'b1;
                    err_d     = err_q | (m_axi_rresp != axi_resp_okay_lp);
                    state_d   = e_op;
                end
            end
            default: state_d = e_op;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= e_op;
            write_q   <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign m_axi_awaddr   = M_AXI_ADDR_WIDTH'(addr_q);
    assign m_axi_awvalid  = aw_v;
    assign m_axi_awid     = '0;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = {1'b0, eff_size(size_q)};
    assign m_axi_awburst  = axi_burst_incr_lp;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = axi_cache_lp;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;

    assign m_axi_wdata    = M_AXI_DATA_WIDTH'({2{data_q}});
    assign m_axi_wstrb    = wstrb_gen(size_q, addr_q[2:0]);
    assign m_axi_wvalid   = w_v;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_bready   = b_rdy;

    assign m_axi_araddr   = M_AXI_ADDR_WIDTH'(addr_q);
    assign m_axi_arvalid  = ar_v;
    assign m_axi_arid     = '0;
    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = {1'b0, eff_size(size_q)};
    assign m_axi_arburst  = axi_burst_incr_lp;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = axi_cache_lp;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_rready   = r_rdy;

    assign io_wr_count_o  = count_q;
    assign io_err_o       = err_q;

    // IDs are always 0 and every transfer is a single beat, so these carry no information.
    logic unused_axi_inputs;
    assign unused_axi_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

endmodule

// File: tb/tb_blackparrot_fpga_host_io_in.sv
// tb/tb_blackparrot_fpga_host_io_in.sv - self-checking bench for blackparrot_fpga_host_io_in
module tb_blackparrot_fpga_host_io_in;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [63:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_awlock, m_axi_arvalid, m_axi_arready, m_axi_arlock;
    logic [3:0]  m_axi_awid, m_axi_awcache, m_axi_awqos, m_axi_awregion;
    logic [3:0]  m_axi_arid, m_axi_arcache, m_axi_arqos, m_axi_arregion;
    logic [7:0]  m_axi_awlen, m_axi_arlen, m_axi_wstrb;
    logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_wvalid, m_axi_wready, m_axi_wlast, m_axi_bvalid, m_axi_bready;
    logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [3:0]  m_axi_bid, m_axi_rid;
    logic        io_cmd_v_i, io_cmd_ready_and_o, io_resp_v_o, io_resp_yumi_i, io_err_o;
    logic [31:0] io_cmd_data_i, io_resp_data_o, io_wr_count_o;

    blackparrot_fpga_host_io_in dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast), .m_axi_rresp(m_axi_rresp),
        .io_cmd_v_i(io_cmd_v_i), .io_cmd_data_i(io_cmd_data_i), .io_cmd_ready_and_o(io_cmd_ready_and_o),
        .io_resp_v_o(io_resp_v_o), .io_resp_data_o(io_resp_data_o), .io_resp_yumi_i(io_resp_yumi_i),
        .io_wr_count_o(io_wr_count_o), .io_err_o(io_err_o)
    );

    int          total = 0;
    int          bad = 0;
    int          exp_count = 0;
    logic        exp_err = 1'b0;
    logic [31:0] resp_q[$];

    localparam logic [29:0] fixed_fields = {4'h0, 8'h00, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'h0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-lane view of a transfer of nbytes starting at addr[2:0], clipped at lane 7.
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] model_strb(input logic [1:0] s, input logic [31:0] a);
        logic [7:0] m = '0;
        int lo = int'(a[2:0]);
        for (int b = 0; b < 8; b++) if (b >= lo && b < lo + nbytes(s)) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] s, input logic [31:0] a, input logic [63:0] rd);
        logic [31:0] r = '0;
        int lo = int'(a[2:0]);
        for (int b = 0; b < nbytes(s); b++) if (lo + b < 8) r[8*b +: 8] = rd[8*(lo+b) +: 8];
        return r;
    endfunction

    function automatic logic [2:0] model_axsize(input logic [1:0] s);
        return (nbytes(s) == 1) ? 3'd0 : (nbytes(s) == 2) ? 3'd1 : 3'd2;
    endfunction

    task automatic push(input logic [31:0] w);
        int c = 0;
        io_cmd_v_i = 1'b1;
        io_cmd_data_i = w;
        while (!io_cmd_ready_and_o && c < 100) begin @(negedge clk); c++; end
        @(negedge clk);
        io_cmd_v_i = 1'b0;
    endtask

    task automatic push_cmd(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        push({w, 29'($urandom), s});
        push(a);
        if (w) push(d);
    endtask

    task automatic pop_resp(input string tag);
        int c = 0;
        logic [31:0] e;
        while (!io_resp_v_o && c < 50) begin @(negedge clk); c++; end
        e = (resp_q.size() > 0) ? resp_q.pop_front() : 32'hx;
        chk({tag, ".resp_v"}, io_resp_v_o, 1);
        chk({tag, ".resp_data"}, io_resp_data_o, e);
        io_resp_yumi_i = io_resp_v_o;
        @(negedge clk);
        io_resp_yumi_i = 1'b0;
    endtask

    task automatic serve_write(input int aw_dly, input int w_dly, input logic [1:0] br,
                               input logic [1:0] s, input logic [31:0] a, input logic [31:0] d, input string tag);
        int c = 0;
        int aw_n = 0;
        int w_n = 0;
        logic extra = 1'b0;
        logic [63:0] cap_addr = '0, cap_data = '0;
        logic [2:0] cap_size = '0;
        logic [7:0] cap_strb = '0;
        logic [29:0] cap_fields = '0;
        logic cap_last = 1'b0;
        while (!m_axi_awvalid && c < 50) begin @(negedge clk); c++; end
        chk({tag, ".awvalid"}, m_axi_awvalid, 1);
        c = 0;
        while ((aw_n == 0 || w_n == 0) && c < 100) begin
            m_axi_awready = (c >= aw_dly);
            m_axi_wready  = (c >= w_dly);
            if ((w_n != 0 && m_axi_wvalid) || (aw_n != 0 && m_axi_awvalid)) extra = 1'b1;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_n++;
                cap_addr = m_axi_awaddr;
                cap_size = m_axi_awsize;
                cap_fields = {m_axi_awid, m_axi_awlen, m_axi_awburst, m_axi_awlock, m_axi_awcache,
                              m_axi_awprot, m_axi_awqos, m_axi_awregion};
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_n++;
                cap_data = m_axi_wdata;
                cap_strb = m_axi_wstrb;
                cap_last = m_axi_wlast;
            end
            @(negedge clk);
            c++;
        end
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        chk({tag, ".aw_beats"}, aw_n, 1);
        chk({tag, ".w_beats"}, w_n, 1);
        chk({tag, ".valid_after_fire"}, extra, 0);
        chk({tag, ".valids_low_in_b"}, {m_axi_awvalid, m_axi_wvalid}, 0);
        chk({tag, ".awaddr"}, cap_addr, {32'h0, a});
        chk({tag, ".awsize"}, cap_size, model_axsize(s));
        chk({tag, ".aw_fields"}, cap_fields, fixed_fields);
        chk({tag, ".wstrb"}, cap_strb, model_strb(s, a));
        chk({tag, ".wdata"}, cap_data, {d, d});
        chk({tag, ".wlast"}, cap_last, 1);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = br;
        c = 0;
        while (!m_axi_bready && c < 20) begin @(negedge clk); c++; end
        chk({tag, ".bready"}, m_axi_bready, 1);
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        exp_count++;
        if (br != 2'b00) exp_err = 1'b1;
        chk({tag, ".count"}, io_wr_count_o, 32'(exp_count));
        chk({tag, ".err"}, io_err_o, exp_err);
    endtask

    task automatic serve_read(input int ar_dly, input logic [63:0] rd, input logic [1:0] rr,
                              input logic [1:0] s, input logic [31:0] a, input string tag,
                              input int stall, input logic do_pop);
        int c = 0;
        logic early = 1'b0;
        while (!m_axi_arvalid && c < 50) begin @(negedge clk); c++; end
        chk({tag, ".arvalid"}, m_axi_arvalid, 1);
        repeat (ar_dly) @(negedge clk);
        chk({tag, ".arvalid_held"}, m_axi_arvalid, 1);
        chk({tag, ".araddr"}, m_axi_araddr, {32'h0, a});
        chk({tag, ".arsize"}, m_axi_arsize, model_axsize(s));
        chk({tag, ".ar_fields"}, {m_axi_arid, m_axi_arlen, m_axi_arburst, m_axi_arlock, m_axi_arcache,
                                  m_axi_arprot, m_axi_arqos, m_axi_arregion}, fixed_fields);
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = rd;
        m_axi_rresp  = rr;
        m_axi_rlast  = 1'b1;
        if (stall > 0) begin
            repeat (stall) begin
                if (m_axi_rready) early = 1'b1;
                @(negedge clk);
            end
            chk({tag, ".rready_low_when_full"}, early, 0);
            pop_resp({tag, ".stall_pop"});
        end
        c = 0;
        while (!m_axi_rready && c < 20) begin @(negedge clk); c++; end
        chk({tag, ".rready"}, m_axi_rready, 1);
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
        resp_q.push_back(model_read(s, a, rd));
        if (rr != 2'b00) exp_err = 1'b1;
        chk({tag, ".err"}, io_err_o, exp_err);
        if (do_pop) pop_resp(tag);
    endtask

    initial begin
        logic        w;
        logic [1:0]  s, r;
        logic [31:0] a, d;
        rst_n = 1'b1;
        io_cmd_v_i = 0; io_cmd_data_i = 0; io_resp_yumi_i = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bid = 0; m_axi_bresp = 0;
        m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.handshake_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                                     io_resp_v_o, io_cmd_ready_and_o}, 0);
        chk("reset.count", io_wr_count_o, 0);
        chk("reset.err", io_err_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        push_cmd(1'b1, 2'd2, 32'h0020_0000, 32'hDEAD_BEEF);
        serve_write(0, 0, 2'b00, 2'd2, 32'h0020_0000, 32'hDEAD_BEEF, "wr4_lo");
        push_cmd(1'b1, 2'd2, 32'h0020_0004, 32'hCAFE_F00D);
        serve_write(1, 0, 2'b00, 2'd2, 32'h0020_0004, 32'hCAFE_F00D, "wr4_hi");
        push_cmd(1'b1, 2'd0, 32'h1234_5673, 32'h0000_00A5);
        serve_write(0, 2, 2'b00, 2'd0, 32'h1234_5673, 32'h0000_00A5, "wr1_b3");
        push_cmd(1'b0, 2'd1, 32'h0000_0006, 32'h0);
        serve_read(0, 64'h1122_3344_5566_7788, 2'b00, 2'd1, 32'h0000_0006, "rd2_b6", 0, 1'b1);
        chk("rd2_b6.err_zero", io_err_o, 0);
        push_cmd(1'b1, 2'd3, 32'h0000_0100, 32'h5A5A_0001);
        serve_write(10, 0, 2'b00, 2'd3, 32'h0000_0100, 32'h5A5A_0001, "aw_stall");
        push_cmd(1'b1, 2'd1, 32'h0000_0202, 32'h0000_BEEF);
        serve_write(0, 0, 2'b10, 2'd1, 32'h0000_0202, 32'h0000_BEEF, "slverr");

        for (int i = 0; i < 16; i++) begin
            w = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            d = $urandom;
            r = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
            push_cmd(w, s, a, d);
            if (w) serve_write($urandom_range(0, 3), $urandom_range(0, 3), r, s, a, d, "rnd_wr");
            else   serve_read($urandom_range(0, 3), {$urandom, $urandom}, r, s, a, "rnd_rd", 0, 1'b1);
        end

        for (int i = 0; i < 64; i++) begin
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            push_cmd(1'b0, s, a, 32'h0);
            serve_read(0, {$urandom, $urandom}, 2'b00, s, a, "fill", 0, 1'b0);
        end
        chk("full.resp_v", io_resp_v_o, 1);
        s = 2'd2;
        a = 32'h0000_0040;
        push_cmd(1'b0, s, a, 32'h0);
        serve_read(0, 64'h0123_4567_89AB_CDEF, 2'b00, s, a, "full", 6, 1'b0);
        for (int i = 0; i < 64; i++) pop_resp("drain");
        chk("drain.empty", io_resp_v_o, 0);

        push_cmd(1'b1, 2'd2, 32'h0000_0300, 32'h7777_8888);
        begin
            int c = 0;
            while (!m_axi_awvalid && c < 50) begin @(negedge clk); c++; end
        end
        chk("midrst.awvalid_before", m_axi_awvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                              io_resp_v_o}, 0);
        chk("midrst.count", io_wr_count_o, 0);
        chk("midrst.err", io_err_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        exp_err = 1'b0;
        @(negedge clk);
        push_cmd(1'b1, 2'd0, 32'h0000_0405, 32'h0000_0033);
        serve_write(0, 0, 2'b00, 2'd0, 32'h0000_0405, 32'h0000_0033, "post_rst_wr");
        push_cmd(1'b0, 2'd2, 32'h0000_0004, 32'h0);
        serve_read(1, 64'hFEDC_BA98_7654_3210, 2'b00, 2'd2, 32'h0000_0004, "post_rst_rd", 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
